kernel_two_vector_alu: RTL and testbench

//  Joins two AXI4-Stream vector inputs (A, B) beat-for-beat and applies a selectable per-lane op.
//  Two-stage registered datapath feeds an internal FIFO; input ready is credit-based so no beat is dropped.

---
 rtl/kernel_two_vector_alu.sv | 206 ++++++++++++++++++++
 tb/tb_kernel_two_vector_alu.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_two_vector_alu.sv
// kernel_two_vector_alu
//   Joins two AXI4-Stream vector inputs (A, B) beat-for-beat and applies a
//   per-lane op selected per beat by ctrl_mode. The path is:
//   join -> d1 (operand regs) -> d2 (lane results) -> FIFO -> output head reg.
//   Input ready is credit based, so no beat is ever dropped inside the block.
// Ports
//   aclk, aresetn          clock, async active-low reset
//   ctrl_mode              00 add, 01 sub (A-B), 10 unsigned sat add, 11 unsigned max
//   ctrl_clear             sync pulse, clears stat_beat_count / stat_tlast_mismatch
//   s_axis_a_*, s_axis_b_* input streams (tvalid/tready/tdata/tkeep/tlast)
//   m_axis_*               result stream, tkeep = a_keep & b_keep, tlast = a_tlast
//   stat_beat_count        joined beats since reset/clear (wraps)
//   stat_tlast_mismatch    sticky, a joined beat had a_tlast != b_tlast

module kernel_two_vector_alu_lane #(
  parameter int W = 32
) (
  input  logic [1:0]   mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  logic [W:0] sum;

  always_comb begin
    y   = '0;
    sum = {1'b0, a} + {1'b0, b};
    case (mode)
      2'b00:   y = sum[W-1:0];
      2'b01:   y = a - b;
      2'b10:   y = sum[W] ? '1 : sum[W-1:0];
      default: y = (a > b) ? a : b;
    endcase
  end
endmodule

module kernel_two_vector_alu #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_LANE_WIDTH       = 32,
  parameter int C_FIFO_DEPTH       = 16,
  parameter int C_COUNT_WIDTH      = 32
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [1:0]                      ctrl_mode,
  input  logic                            ctrl_clear,
  input  logic                            s_axis_a_tvalid,
  output logic                            s_axis_a_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_a_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_a_tkeep,
  input  logic                            s_axis_a_tlast,
  input  logic                            s_axis_b_tvalid,
  output logic                            s_axis_b_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_b_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_b_tkeep,
  input  logic                            s_axis_b_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic [C_COUNT_WIDTH-1:0]        stat_beat_count,
  output logic                            stat_tlast_mismatch
);
  localparam int TDW    = C_AXIS_TDATA_WIDTH;
  localparam int KW     = TDW / 8;
  localparam int LW     = C_LANE_WIDTH;
  localparam int LANES  = TDW / LW;
  localparam int AW     = $clog2(C_FIFO_DEPTH);
  localparam int STAGES = 2;

  typedef struct packed {
    logic [TDW-1:0] data;
    logic [KW-1:0]  keep;
    logic           last;
  } beat_t;

  // en_q keeps both treadys low until the first edge after reset release.
  logic                         en_q, en_d;
  logic [STAGES-1:0]            vld_pipe_q, vld_pipe_d;   // [0]=d1, [1]=d2
  logic [LANES-1:0][LW-1:0]     d1_a_q, d1_a_d, d1_b_q, d1_b_d;
  logic [KW-1:0]                d1_keep_q, d1_keep_d;
  logic                         d1_last_q, d1_last_d;
  logic [1:0]                   d1_mode_q, d1_mode_d;
  logic [LANES-1:0][LW-1:0]     alu_y;
  beat_t                        d2_q, d2_d;
  beat_t                        mem_q [C_FIFO_DEPTH];
  logic [AW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]                  mem_cnt_q, mem_cnt_d;
  beat_t                        out_q, out_d;
  logic                         out_vld_q, out_vld_d;
  logic [C_COUNT_WIDTH-1:0]     beat_cnt_q, beat_cnt_d;
  logic                         mism_q, mism_d;
  logic [AW+1:0]                occupancy;
  logic                         credit_ok, accept, push, pop;

  // Occupancy counts every beat the block owns: in d1/d2, in the FIFO
  // memory and in the output head register. Total never exceeds DEPTH.
  assign occupancy = (AW+2)'(mem_cnt_q) + (AW+2)'(out_vld_q)
                   + (AW+2)'(vld_pipe_q[0]) + (AW+2)'(vld_pipe_q[1]);
  assign credit_ok = en_q && (occupancy <= (AW+2)'(C_FIFO_DEPTH - 1));
  assign accept    = credit_ok && s_axis_a_tvalid && s_axis_b_tvalid;
  assign push      = vld_pipe_q[1];
  // Head register refills from memory whenever it is empty or being drained.
  assign pop       = (mem_cnt_q != '0) && (!out_vld_q || m_axis_tready);

  assign s_axis_a_tready = credit_ok && s_axis_b_tvalid;
  assign s_axis_b_tready = credit_ok && s_axis_a_tvalid;

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      kernel_two_vector_alu_lane #(.W(LW)) u_lane (
        .mode (d1_mode_q),
        .a    (d1_a_q[g]),
        .b    (d1_b_q[g]),
        .y    (alu_y[g])
      );
    end
  endgenerate

  always_comb begin
    en_d       = 1'b1;
    vld_pipe_d = {vld_pipe_q[0], accept};
    d1_a_d     = d1_a_q;
    d1_b_d     = d1_b_q;
    d1_keep_d  = d1_keep_q;
    d1_last_d  = d1_last_q;
    d1_mode_d  = d1_mode_q;
    d2_d       = d2_q;
    if (accept) begin
      d1_a_d    = s_axis_a_tdata;
      d1_b_d    = s_axis_b_tdata;
      d1_keep_d = s_axis_a_tkeep & s_axis_b_tkeep;
      d1_last_d = s_axis_a_tlast;
      d1_mode_d = ctrl_mode;
    end
    if (vld_pipe_q[0]) begin
      d2_d.data = alu_y;
      d2_d.keep = d1_keep_q;
      d2_d.last = d1_last_q;
    end
    wr_ptr_d  = wr_ptr_q + AW'(push);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    mem_cnt_d = mem_cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    out_d     = pop ? mem_q[rd_ptr_q] : out_q;
    out_vld_d = pop || (out_vld_q && !m_axis_tready);
    // A clear coinciding with a transfer leaves the count at 1; a mismatch
    // set wins over a coincident clear.
    beat_cnt_d = ctrl_clear ? C_COUNT_WIDTH'(accept)
                            : beat_cnt_q + C_COUNT_WIDTH'(accept);
    mism_d     = (mism_q && !ctrl_clear)
              || (accept && (s_axis_a_tlast != s_axis_b_tlast));
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      en_q       <= 1'b0;
      vld_pipe_q <= '0;
      d1_a_q     <= '0;
      d1_b_q     <= '0;
      d1_keep_q  <= '0;
      d1_last_q  <= 1'b0;
      d1_mode_q  <= '0;
      d2_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      beat_cnt_q <= '0;
      mism_q     <= 1'b0;
    end else begin
      en_q       <= en_d;
      vld_pipe_q <= vld_pipe_d;
      d1_a_q     <= d1_a_d;
      d1_b_q     <= d1_b_d;
      d1_keep_q  <= d1_keep_d;
      d1_last_q  <= d1_last_d;
      d1_mode_q  <= d1_mode_d;
      d2_q       <= d2_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      beat_cnt_q <= beat_cnt_d;
      mism_q     <= mism_d;
    end
  end

  // Storage only; contents are qualified by the pointers/count above.
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= d2_q;
  end

  a_fifo_no_overflow: assert property (@(posedge aclk) disable iff (!aresetn)
    push |-> (mem_cnt_q != (AW+1)'(C_FIFO_DEPTH)));

  assign m_axis_tvalid       = out_vld_q;
  assign m_axis_tdata        = out_q.data;
  assign m_axis_tkeep        = out_q.keep;
  assign m_axis_tlast        = out_q.last;
  assign stat_beat_count     = beat_cnt_q;
  assign stat_tlast_mismatch = mism_q;
endmodule

// File: tb/tb_kernel_two_vector_alu.sv
// Directed bench for kernel_two_vector_alu: a high-level model predicts each
// output beat from the joined inputs, a compare process checks outputs,
// handshake rules and statistics every cycle, and literals pin key results.
module tb_kernel_two_vector_alu;
  localparam int TDW   = 512;
  localparam int KW    = TDW / 8;
  localparam int LW    = 32;
  localparam int LANES = TDW / LW;

  typedef struct packed {
    logic [TDW-1:0] data;
    logic [KW-1:0]  keep;
    logic           last;
  } exp_t;

  logic           aclk = 1'b0;
  logic           aresetn;
  logic [1:0]     ctrl_mode;
  logic           ctrl_clear;
  logic           a_vld, a_rdy, a_last, b_vld, b_rdy, b_last;
  logic [TDW-1:0] a_data, b_data;
  logic [KW-1:0]  a_keep, b_keep;
  logic           m_vld, m_rdy, m_last;
  logic [TDW-1:0] m_data;
  logic [KW-1:0]  m_keep;
  logic [31:0]    stat_cnt;
  logic           stat_mism;

  always #5 aclk = ~aclk;

  kernel_two_vector_alu dut (
    .aclk(aclk), .aresetn(aresetn), .ctrl_mode(ctrl_mode), .ctrl_clear(ctrl_clear),
    .s_axis_a_tvalid(a_vld), .s_axis_a_tready(a_rdy), .s_axis_a_tdata(a_data),
    .s_axis_a_tkeep(a_keep), .s_axis_a_tlast(a_last),
    .s_axis_b_tvalid(b_vld), .s_axis_b_tready(b_rdy), .s_axis_b_tdata(b_data),
    .s_axis_b_tkeep(b_keep), .s_axis_b_tlast(b_last),
    .m_axis_tvalid(m_vld), .m_axis_tready(m_rdy), .m_axis_tdata(m_data),
    .m_axis_tkeep(m_keep), .m_axis_tlast(m_last),
    .stat_beat_count(stat_cnt), .stat_tlast_mismatch(stat_mism)
  );

  int n_chk = 0, n_pass = 0, cyc = 0;
  int first_acc = -1, last_acc = -1, first_vld = -1;
  bit arm_lat = 0;
  exp_t exp_q[$];
  logic [TDW-1:0] out_data_log[$];
  logic           out_last_log[$];
  int             mdl_cnt = 0;
  bit             mdl_mism = 0;
  bit             stall_prev = 0;
  logic [TDW-1:0] prev_data;

  always @(posedge aclk) cyc++;

  task automatic check(input string name, input logic [TDW-1:0] act, input logic [TDW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [TDW-1:0] mk(input logic [31:0] base, input logic [31:0] step);
    logic [TDW-1:0] v;
    v = '0;
    for (int j = 0; j < LANES; j++) v[j*LW +: LW] = base + 32'(j) * step;
    return v;
  endfunction

  // Lane results from plain integer arithmetic on each lane value.
  function automatic logic [TDW-1:0] model_op(input logic [TDW-1:0] a, input logic [TDW-1:0] b,
                                              input logic [1:0] mode);
    logic [TDW-1:0] res;
    longint unsigned x, y, r, m;
    res = '0;
    m = 64'd1 << LW;
    for (int j = 0; j < LANES; j++) begin
      x = 64'(a[j*LW +: LW]);
      y = 64'(b[j*LW +: LW]);
      case (mode)
        2'd0:    r = (x + y) % m;
        2'd1:    r = (x + m - y) % m;
        2'd2:    r = (x + y >= m) ? m - 1 : x + y;
        default: r = (x > y) ? x : y;
      endcase
      res[j*LW +: LW] = r[LW-1:0];
    end
    return res;
  endfunction

  // Compare process: runs on every falling edge.
  always @(negedge aclk) begin
    bit hs;
    exp_t e;
    if (!aresetn) begin
      exp_q.delete();
      mdl_cnt = 0;
      mdl_mism = 0;
      stall_prev = 0;
      check("rst_tvalid", TDW'(m_vld), '0);
      check("rst_treadys", TDW'({a_rdy, b_rdy}), '0);
    end else begin
      hs = a_vld && a_rdy && b_vld && b_rdy;
      check("join_rule", TDW'(!(a_rdy && !b_vld) && !(b_rdy && !a_vld)
                              && (!(a_vld && b_vld) || (a_rdy == b_rdy))), TDW'(1));
      check("stat_count", TDW'(stat_cnt), TDW'(mdl_cnt));
      check("stat_mismatch", TDW'(stat_mism), TDW'(mdl_mism));
      if (stall_prev) begin
        check("hold_tvalid", TDW'(m_vld), TDW'(1));
        check("hold_tdata", m_data, prev_data);
      end
      if (m_vld && m_rdy) begin
        if (exp_q.size() == 0) check("unexpected_out", TDW'(1), '0);
        else begin
          e = exp_q.pop_front();
          check("out_tdata", m_data, e.data);
          check("out_tkeep", TDW'(m_keep), TDW'(e.keep));
          check("out_tlast", TDW'(m_last), TDW'(e.last));
        end
        out_data_log.push_back(m_data);
        out_last_log.push_back(m_last);
      end
      if (arm_lat && first_acc >= 0 && first_vld < 0 && m_vld) first_vld = cyc;
      stall_prev = m_vld && !m_rdy;
      prev_data  = m_data;
      if (hs) begin
        e.data = model_op(a_data, b_data, ctrl_mode);
        e.keep = a_keep & b_keep;
        e.last = a_last;
        exp_q.push_back(e);
        if (arm_lat) begin
          if (first_acc < 0) first_acc = cyc + 1;
          last_acc = cyc + 1;
        end
      end
      mdl_cnt  = ctrl_clear ? int'(hs) : mdl_cnt + int'(hs);
      mdl_mism = (mdl_mism && !ctrl_clear) || (hs && (a_last != b_last));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic [TDW-1:0] a, input logic [TDW-1:0] b, input logic [KW-1:0] ak,
                       input logic [KW-1:0] bk, input logic al, input logic bl, input logic [1:0] md);
    a_data = a; b_data = b; a_keep = ak; b_keep = bk;
    a_last = al; b_last = bl; ctrl_mode = md;
  endtask

  task automatic send(input logic [TDW-1:0] a, input logic [TDW-1:0] b, input logic [KW-1:0] ak,
                      input logic [KW-1:0] bk, input logic al, input logic bl, input logic [1:0] md);
    int t;
    bit done;
    drive(a, b, ak, bk, al, bl, md);
    a_vld = 1; b_vld = 1;
    t = 0; done = 0;
    while (!done) begin
      @(negedge aclk);
      if (a_vld && a_rdy && b_vld && b_rdy) done = 1;
      else if (++t > 200) begin check("send_timeout", '0, TDW'(1)); done = 1; end
    end
    @(posedge aclk); #1;
    a_vld = 0; b_vld = 0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin @(negedge aclk); t++; end
    if (exp_q.size() != 0) check("drain_timeout", TDW'(exp_q.size()), '0);
    step(1);
  endtask

  initial begin
    int base, nacc, k;
    bit acc;
    logic [TDW-1:0] v;
    aresetn = 0; ctrl_clear = 0; m_rdy = 1;
    a_vld = 0; b_vld = 0;
    drive('0, '0, '0, '0, 0, 0, 2'd0);
    step(3);
    check("rst_count", TDW'(stat_cnt), '0);
    check("rst_mism", TDW'(stat_mism), '0);
    aresetn = 1;
    step(2);

    // T1: add, back-to-back, latency and throughput
    arm_lat = 1;
    for (int i = 0; i < 8; i++) send(mk(i, 1), mk(32'h10, 0), '1, '1, i == 7, i == 7, 2'd0);
    drain();
    arm_lat = 0;
    check("t1_latency", TDW'(first_vld - first_acc), TDW'(3));
    check("t1_throughput", TDW'(last_acc - first_acc), TDW'(7));
    v = out_data_log[0];
    check("t1_beat0_lane0", TDW'(v[31:0]), TDW'(32'h10));
    v = out_data_log[7];
    check("t1_beat7_lane15", TDW'(v[15*LW +: LW]), TDW'(32'h26));
    check("t1_count", TDW'(stat_cnt), TDW'(8));

    // T2: sub / sat add / max boundaries
    base = out_data_log.size();
    send(mk(1, 0), mk(32'hFFFF_FFFF, 0), '1, '1, 0, 0, 2'd1);
    send(mk(1, 0), mk(32'hFFFF_FFFF, 0), '1, '1, 0, 0, 2'd2);
    send(mk(1, 0), mk(32'hFFFF_FFFF, 0), '1, '1, 0, 0, 2'd3);
    send(mk(5, 0), mk(3, 0), '1, '1, 1, 1, 2'd3);
    drain();
    v = out_data_log[base];
    check("t2_sub", v, mk(2, 0));
    v = out_data_log[base+1];
    check("t2_satadd", TDW'(v[31:0]), TDW'(32'hFFFF_FFFF));
    v = out_data_log[base+2];
    check("t2_max", TDW'(v[LW +: LW]), TDW'(32'hFFFF_FFFF));
    v = out_data_log[base+3];
    check("t2_max_a", TDW'(v[31:0]), TDW'(5));

    // T3: A waits for B
    drive(mk(9, 0), mk(4, 0), '1, 64'hFFFF_0000_FFFF_0000, 0, 0, 2'd1);
    a_vld = 1; b_vld = 0;
    repeat (5) begin
      @(negedge aclk);
      check("t3_a_blocked", TDW'(a_rdy), '0);
    end
    @(posedge aclk); #1;
    b_vld = 1;
    @(negedge aclk);
    check("t3_both_ready", TDW'({a_rdy, b_rdy}), TDW'(2'b11));
    @(posedge aclk); #1;
    a_vld = 0; b_vld = 0;
    check("t3_count", TDW'(stat_cnt), TDW'(13));
    drain();

    // T4: output stalled, credit stops input at exactly DEPTH beats
    m_rdy = 0; k = 0; nacc = 0;
    drive(mk(100, 1), mk(0, 0), '1, '1, 0, 0, 2'd0);
    a_vld = 1; b_vld = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge aclk);
      acc = a_vld && a_rdy && b_vld && b_rdy;
      if (acc) nacc++;
      @(posedge aclk); #1;
      if (acc) begin
        k++;
        drive(mk(100 + k, 1), mk(k, 0), '1, '1, 0, 0, 2'd0);
      end
    end
    check("t4_accepted", TDW'(nacc), TDW'(16));
    @(negedge aclk);
    check("t4_full_tready", TDW'({a_rdy, b_rdy}), '0);
    @(posedge aclk); #1;
    a_vld = 0; b_vld = 0; m_rdy = 1;
    drain();
    v = out_data_log[out_data_log.size()-1];
    check("t4_last_lane0", TDW'(v[31:0]), TDW'(130));

    // T5: tlast mismatch, clear, set-beats-clear
    base = out_data_log.size();
    for (int i = 0; i < 5; i++) send(mk(i, 0), mk(i, 0), '1, 64'h0F0F_0F0F_0F0F_0F0F, i == 3, 0, 2'd0);
    drain();
    check("t5_mism", TDW'(stat_mism), TDW'(1));
    check("t5_tlast_beat3", TDW'(out_last_log[base+3]), TDW'(1));
    check("t5_tlast_beat2", TDW'(out_last_log[base+2]), '0);
    ctrl_clear = 1;
    step(1);
    ctrl_clear = 0;
    check("t5_clear_mism", TDW'(stat_mism), '0);
    check("t5_clear_count", TDW'(stat_cnt), '0);
    ctrl_clear = 1;
    send(mk(7, 0), mk(1, 0), '1, '1, 0, 1, 2'd1);
    ctrl_clear = 0;
    check("t5_set_wins", TDW'(stat_mism), TDW'(1));
    check("t5_clear_with_xfer", TDW'(stat_cnt), TDW'(1));
    drain();

    // T6: reset with 10 beats buffered
    m_rdy = 0;
    for (int i = 0; i < 10; i++) send(mk(200 + i, 0), mk(0, 0), '1, '1, 0, 0, 2'd0);
    step(3);
    drive(mk(77, 0), mk(1, 0), '1, '1, 1, 1, 2'd0);
    a_vld = 1; b_vld = 1;
    #1 aresetn = 0;
    #1;
    check("t6_async_tvalid", TDW'(m_vld), '0);
    check("t6_async_treadys", TDW'({a_rdy, b_rdy}), '0);
    check("t6_async_count", TDW'(stat_cnt), '0);
    base = out_data_log.size();
    step(2);
    m_rdy = 1;
    aresetn = 1;
    send(mk(77, 0), mk(1, 0), '1, '1, 1, 1, 2'd0);
    drain();
    step(3);
    check("t6_one_output", TDW'(out_data_log.size() - base), TDW'(1));
    v = out_data_log[out_data_log.size()-1];
    check("t6_new_beat", TDW'(v[31:0]), TDW'(78));
    check("t6_count", TDW'(stat_cnt), TDW'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end
endmodule
